// File: rtl/unsaved_led_pwm.sv
// Avalon-MM LED dimmer/blinker: per-LED 8-bit PWM duty, frame-based blink,
// master enable; sits between a PIO out_port and the physical LEDs.
module unsaved_led_pwm #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [3:0]  led_in,
   output logic [3:0]  led_out
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic [31:0] r_duty;
   logic        r_enable;
   logic [3:0]  r_blink_mask;
   logic [15:0] r_blink_period;
   logic [15:0] r_presc;
   logic [7:0]  r_pwm_cnt;
   logic [15:0] r_blink_cnt;
   logic        r_blink_phase;
   logic [3:0]  r_led_out;

   logic        w_wr;
   logic        w_wr_duty;
   logic        w_wr_ctrl;
   logic        w_wr_bp;
   logic        w_tick;
   logic        w_frame_end;
   logic [3:0]  w_pwm_on;
   logic [3:0]  w_led_nxt;
   logic [15:0] w_blink_cnt_nxt;
   logic        w_blink_phase_nxt;

   assign w_wr        = chipselect & ~write_n;
   assign w_wr_duty   = w_wr & (address == 2'd0);
   assign w_wr_ctrl   = w_wr & (address == 2'd1);
   assign w_wr_bp     = w_wr & (address == 2'd2);
   assign w_tick      = (r_presc == PS_LAST);
   assign w_frame_end = w_tick & (r_pwm_cnt == 8'hFF);
   assign led_out     = r_led_out;

   // Bus-visible configuration registers; STATUS (address 3) is read-only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_duty         <= 32'hFFFF_FFFF;
         r_enable       <= 1'b1;
         r_blink_mask   <= 4'h0;
         r_blink_period <= 16'd100;
      end else begin
         if (w_wr_duty) begin
            r_duty <= writedata;
         end
         if (w_wr_ctrl) begin
            r_enable     <= writedata[4];
            r_blink_mask <= writedata[3:0];
         end
         if (w_wr_bp) begin
            r_blink_period <= writedata[15:0];
         end
      end
   end

   // Prescaler and PWM frame counter free-run; enable only gates the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc   <= 16'd0;
         r_pwm_cnt <= 8'd0;
      end else if (w_tick) begin
         r_presc   <= 16'd0;
         r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
         r_presc   <= r_presc + 16'd1;
      end
   end

   // Blink next state; a BLINK_PERIOD write takes priority over frame_end.
   always_comb begin
      w_blink_cnt_nxt   = r_blink_cnt;
      w_blink_phase_nxt = r_blink_phase;
      if (w_wr_bp || (r_blink_period == 16'd0)) begin
         w_blink_cnt_nxt   = 16'd0;
         w_blink_phase_nxt = 1'b1;
      end else if (w_frame_end) begin
         if (r_blink_cnt == (r_blink_period - 16'd1)) begin
            w_blink_cnt_nxt   = 16'd0;
            w_blink_phase_nxt = ~r_blink_phase;
         end else begin
            w_blink_cnt_nxt   = r_blink_cnt + 16'd1;
         end
      end else begin
         w_blink_cnt_nxt   = r_blink_cnt;
      end
   end

   // Blink counter and phase registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt   <= 16'd0;
         r_blink_phase <= 1'b1;
      end else begin
         r_blink_cnt   <= w_blink_cnt_nxt;
         r_blink_phase <= w_blink_phase_nxt;
      end
   end

   // Per-LED PWM compare and output gating; duty 0xFF is forced fully on.
   always_comb begin
      w_pwm_on  = 4'h0;
      w_led_nxt = 4'h0;
      for (int i = 0; i < 4; i++) begin
         w_pwm_on[i]  = (r_duty[i*8 +: 8] == 8'hFF) || (r_pwm_cnt < r_duty[i*8 +: 8]);
         w_led_nxt[i] = r_enable & led_in[i] & w_pwm_on[i] &
                        (~r_blink_mask[i] | r_blink_phase);
      end
   end

   // Registered LED drive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_led_out <= 4'h0;
      end else begin
         r_led_out <= w_led_nxt;
      end
   end

   // Zero-wait read mux, independent of chipselect.
   always_comb begin
      readdata = 32'h0000_0000;
      case (address)
         2'd0:    readdata = r_duty;
         2'd1:    readdata = {27'd0, r_enable, r_blink_mask};
         2'd2:    readdata = {16'd0, r_blink_period};
         2'd3:    readdata = {23'd0, r_blink_phase, r_pwm_cnt};
         default: readdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_unsaved_led_pwm.sv
// Directed self-checking bench for unsaved_led_pwm at PRESCALE=4
// (one PWM frame = 1024 clk).
module tb_unsaved_led_pwm;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  led_in;
   logic [3:0]  led_out;

   int checks = 0;
   int errors = 0;
   int cyc;

   unsaved_led_pwm #(.PRESCALE(4)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .led_in(led_in), .led_out(led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference count of clock edges since reset release.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   function automatic logic [31:0] status_model(input logic phase);
      return {23'd0, phase, 8'((cyc >> 2) % 256)};
   endfunction

   // Leaves the bench at the negedge just before a frame_end edge.
   task automatic wait_fe();
      int n = 0;
      while ((cyc % 1024 != 1023) && (n < 2100)) begin
         @(negedge clk);
         n++;
      end
      check("frame_end_wait", 32'(n < 2100), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      int hi [4];
      int tt [3];
      int nt;
      int lows;
      int n;
      logic prev;

      reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'd0; led_in = 4'h7;

      // Reset state and register defaults
      repeat (3) @(negedge clk);
      check("rst_led_out", 32'(led_out), 32'h0);
      bus_read(2'd0, rd); check("rst_duty", rd, 32'hFFFF_FFFF);
      bus_read(2'd1, rd); check("rst_ctrl", rd, 32'h0000_0010);
      bus_read(2'd2, rd); check("rst_bp", rd, 32'd100);
      bus_read(2'd3, rd); check("rst_status", rd, 32'h0000_0100);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("transparent_7", 32'(led_out), 32'h7);
      led_in = 4'hA;
      #1;
      check("led_registered", 32'(led_out), 32'h7);
      @(negedge clk);
      check("transparent_A", 32'(led_out), 32'hA);

      // PWM duty over one full frame
      led_in = 4'hF;
      bus_write(2'd0, 32'h0040_80FF);
      for (int j = 0; j < 4; j++) hi[j] = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) hi[j] += int'(led_out[j]);
      end
      check("duty_led0", 32'(hi[0]), 32'd1024);
      check("duty_led1", 32'(hi[1]), 32'd512);
      check("duty_led2", 32'(hi[2]), 32'd256);
      check("duty_led3", 32'(hi[3]), 32'd0);

      // Disable: output forced low, counters keep running, STATUS read-only
      bus_write(2'd1, 32'h0000_0000);
      @(negedge clk);
      check("disable_led_out", 32'(led_out), 32'h0);
      bus_read(2'd3, rd); check("status_run_a", rd, status_model(1'b1));
      repeat (4) @(negedge clk);
      bus_read(2'd3, rd); check("status_run_b", rd, status_model(1'b1));
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_read(2'd3, rd); check("status_after_wr3", rd, status_model(1'b1));
      bus_read(2'd0, rd); check("duty_after_wr3", rd, 32'h0040_80FF);
      bus_read(2'd1, rd); check("ctrl_after_wr3", rd, 32'h0000_0000);
      bus_read(2'd2, rd); check("bp_after_wr3", rd, 32'd100);

      // Blink with period 2 frames on LED0
      bus_write(2'd0, 32'hFFFF_FFFF);
      bus_write(2'd1, 32'h0000_0011);
      led_in = 4'h1;
      bus_write(2'd2, 32'd2);
      bus_read(2'd1, rd); check("ctrl_rb", rd, 32'h0000_0011);
      @(negedge clk);
      prev = led_out[0];
      check("blink_start_phase", 32'(prev), 32'd1);
      nt = 0;
      for (int i = 0; i < 8192; i++) begin
         @(negedge clk);
         if (led_out[0] !== prev) begin
            if (nt < 3) tt[nt] = i;
            nt++;
            prev = led_out[0];
         end
      end
      check("blink_toggle_count", 32'(nt), 32'd4);
      check("blink_first_le_2frames", 32'(tt[0] <= 2048), 32'd1);
      check("blink_interval_1", 32'(tt[1] - tt[0]), 32'd2048);
      check("blink_interval_2", 32'(tt[2] - tt[1]), 32'd2048);

      // BLINK_PERIOD=0: steady on, phase forced to 1
      bus_write(2'd2, 32'd0);
      @(negedge clk);
      lows = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (led_out[0] !== 1'b1) lows++;
      end
      check("bp0_steady_on", 32'(lows), 32'd0);
      bus_read(2'd2, rd); check("bp0_readback", rd, 32'd0);
      bus_read(2'd3, rd); check("bp0_phase", 32'(rd[8]), 32'd1);

      // BLINK_PERIOD write on the exact frame_end edge wins
      bus_write(2'd2, 32'd2);
      wait_fe(); @(negedge clk);
      wait_fe(); @(negedge clk);
      bus_read(2'd3, rd); check("phase_low_before", 32'(rd[8]), 32'd0);
      wait_fe();
      address = 2'd2; writedata = 32'd2; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      bus_read(2'd3, rd); check("write_wins_phase", 32'(rd[8]), 32'd1);
      wait_fe(); @(negedge clk);
      bus_read(2'd3, rd); check("cnt_cleared_phase", 32'(rd[8]), 32'd1);
      wait_fe(); @(negedge clk);
      bus_read(2'd3, rd); check("phase_toggle_after", 32'(rd[8]), 32'd0);

      // Asynchronous reset mid-frame with pwm_cnt=0x37 and phase 0
      bus_write(2'd1, 32'h0000_0010);
      led_in = 4'hF;
      n = 0;
      while ((((cyc >> 2) % 256) != 32'h37) && (n < 1100)) begin
         @(negedge clk);
         n++;
      end
      check("pwm37_wait", 32'(n < 1100), 32'd1);
      bus_read(2'd3, rd); check("pre_reset_status", rd, 32'h0000_0037);
      check("pre_reset_led", 32'(led_out), 32'hF);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_led", 32'(led_out), 32'h0);
      bus_read(2'd3, rd); check("async_rst_status", rd, 32'h0000_0100);
      @(negedge clk);
      bus_read(2'd1, rd); check("async_rst_ctrl", rd, 32'h0000_0010);
      bus_read(2'd2, rd); check("async_rst_bp", rd, 32'd100);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_transparent", 32'(led_out), 32'hF);
      bus_read(2'd3, rd); check("post_reset_status", rd, status_model(1'b1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
